// File: rtl/conv_encoder_r12.sv
// -----------------------------------------------------------------------------
// conv_encoder_r12
//   Rate-1/2 feed-forward convolutional encoder. Takes one info bit per
//   accepted beat and produces one 2-bit code symbol per beat. Every frame of
//   FRAME_LEN info bits is followed by K-1 zero tail bits, so each frame starts
//   and ends in trellis state 0.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous, active-low reset
//   din_valid    in   upstream info bit valid
//   din          in   info bit
//   din_ready    out  encoder accepts din this cycle
//   enc_valid    out  enc_out holds a valid code symbol
//   enc_out      out  {G1 parity, G0 parity}
//   enc_ready    in   downstream consumes enc_out this cycle
//   frame_start  out  qualifies enc_out: first symbol of a frame
//   frame_end    out  qualifies enc_out: last tail symbol of a frame
//   enc_state    out  current trellis state (shift register contents)
// -----------------------------------------------------------------------------
module conv_encoder_r12 #(
  parameter int           K         = 3,
  parameter logic [K-1:0] G0        = 3'b111,
  parameter logic [K-1:0] G1        = 3'b101,
  parameter int           FRAME_LEN = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din_valid,
  input  logic         din,
  output logic         din_ready,
  output logic         enc_valid,
  output logic [1:0]   enc_out,
  input  logic         enc_ready,
  output logic         frame_start,
  output logic         frame_end,
  output logic [K-2:0] enc_state
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int TW = (K > 2) ? $clog2(K - 1) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] LAST_TAIL = TW'(K - 2);

  typedef enum logic {
    ST_DATA,
    ST_TAIL
  } state_t;

  state_t        state_q;
  logic [CW-1:0] count_q;
  logic [TW-1:0] tcount_q;
  logic [K-2:0]  sr_q;
  logic [K-2:0]  sr_d;

  logic          enc_valid_q;
  logic [1:0]    enc_out_q;
  logic          frame_start_q;
  logic          frame_end_q;

  logic          adv;
  logic          encode;
  logic          in_bit;
  logic [K-1:0]  win;
  logic [1:0]    parity_d;

  // The output register may load whenever it is empty or being drained.
  assign adv       = !enc_valid_q || enc_ready;
  assign din_ready = (state_q == ST_DATA) && adv;

  // In TAIL every advance encodes a forced zero; in DATA only accepted bits.
  assign encode    = (state_q == ST_TAIL) ? adv : (din_valid && din_ready);
  assign in_bit    = (state_q == ST_DATA) && din;

  // Window MSB is the current bit, followed by the most recent history bit.
  assign win       = {in_bit, sr_q};
  assign parity_d  = {^(win & G1), ^(win & G0)};

  // Shift the new bit in at the top; the oldest history bit falls off sr[0].
  generate
    if (K == 2) begin : g_sr_single
      assign sr_d = in_bit;
    end else begin : g_sr_multi
      assign sr_d = {in_bit, sr_q[K-2:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_DATA;
      count_q       <= '0;
      tcount_q      <= '0;
      sr_q          <= '0;
      enc_valid_q   <= 1'b0;
      enc_out_q     <= 2'b00;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
    end else begin
      // Output register: loads on advance, otherwise holds the stalled symbol.
      if (adv) begin
        enc_valid_q   <= encode;
        frame_start_q <= encode && (state_q == ST_DATA) && (count_q == '0);
        frame_end_q   <= encode && (state_q == ST_TAIL) && (tcount_q == LAST_TAIL);
        if (encode) begin
          enc_out_q <= parity_d;
        end
      end

      if (encode) begin
        sr_q <= sr_d;
        case (state_q)
          ST_DATA: begin
            if (count_q == LAST_BIT) begin
              state_q  <= ST_TAIL;
              count_q  <= '0;
              tcount_q <= '0;
            end else begin
              count_q <= count_q + CW'(1);
            end
          end
          ST_TAIL: begin
            // K-1 zero tail bits flush the register, so sr is 0 here.
            if (tcount_q == LAST_TAIL) begin
              state_q  <= ST_DATA;
              tcount_q <= '0;
              count_q  <= '0;
            end else begin
              tcount_q <= tcount_q + TW'(1);
            end
          end
          default: state_q <= ST_DATA;
        endcase
      end
    end
  end

  assign enc_valid   = enc_valid_q;
  assign enc_out     = enc_out_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign enc_state   = sr_q;

endmodule

// File: tb/tb_conv_encoder_r12.sv
// -----------------------------------------------------------------------------
// tb_conv_encoder_r12
//   Directed table of per-cycle vectors for the default encoder (K=3, G0=111,
//   G1=101, 6 info bits per frame), a reset-mid-frame sequence, and a random
//   frame run against a convolution reference and a 16-bit word packer.
// -----------------------------------------------------------------------------
module tb_conv_encoder_r12;

  localparam int NF = 1000;
  localparam int NB = NF * 6;
  localparam int NS = NF * 8;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       din_valid = 1'b0;
  logic       din       = 1'b0;
  logic       enc_ready = 1'b0;
  logic       din_ready;
  logic       enc_valid;
  logic [1:0] enc_out;
  logic       frame_start;
  logic       frame_end;
  logic [1:0] enc_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv_encoder_r12 dut (
    .clk         (clk),
    .rst         (rst),
    .din_valid   (din_valid),
    .din         (din),
    .din_ready   (din_ready),
    .enc_valid   (enc_valid),
    .enc_out     (enc_out),
    .enc_ready   (enc_ready),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .enc_state   (enc_state)
  );

  // One row per clock: inputs driven for that cycle, din_ready expected
  // before the edge, outputs expected after the edge.
  typedef struct {
    logic       dv;
    logic       d;
    logic       rdy;
    logic       exp_dr;
    logic       exp_v;
    logic [1:0] exp_o;
    logic       exp_fs;
    logic       exp_fe;
    logic [1:0] exp_st;
  } vec_t;

  vec_t vecs[64];
  int   nv;

  logic       rbits[NB];
  logic [1:0] esym[NS];

  function automatic vec_t mk(input logic dv, input logic d, input logic rdy,
                              input logic dr, input logic v, input logic [1:0] o,
                              input logic fs, input logic fe, input logic [1:0] st);
    vec_t r;
    r.dv = dv; r.d = d; r.rdy = rdy; r.exp_dr = dr; r.exp_v = v;
    r.exp_o = o; r.exp_fs = fs; r.exp_fe = fe; r.exp_st = st;
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic run_rows(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      din_valid = vecs[i].dv;
      din       = vecs[i].d;
      enc_ready = vecs[i].rdy;
      #1;
      check($sformatf("%s_r%0d_din_ready", tag, i), {15'b0, din_ready}, {15'b0, vecs[i].exp_dr});
      @(posedge clk);
      #1;
      check($sformatf("%s_r%0d_valid", tag, i), {15'b0, enc_valid}, {15'b0, vecs[i].exp_v});
      check($sformatf("%s_r%0d_state", tag, i), {14'b0, enc_state}, {14'b0, vecs[i].exp_st});
      if (vecs[i].exp_v)
        check($sformatf("%s_r%0d_sym", tag, i), {12'b0, enc_out, frame_start, frame_end},
              {12'b0, vecs[i].exp_o, vecs[i].exp_fs, vecs[i].exp_fe});
      $display("%s row %0d: dv=%b d=%b rdy=%b -> dr=%b v=%b out=%b fs=%b fe=%b st=%b",
               tag, i, din_valid, din, enc_ready, din_ready, enc_valid, enc_out,
               frame_start, frame_end, enc_state);
    end
  endtask

  // Info bit n of frame f, zero outside 0..5 (history before start, tail after).
  function automatic logic ub(input int f, input int n);
    if (n < 0 || n > 5) return 1'b0;
    return rbits[f * 6 + n];
  endfunction

  initial begin
    // ---------------- table ----------------
    nv = 0;
    // Frame 1,0,0,0,0,0 (rows 0-7)
    vecs[nv++] = mk(1,1,1, 1, 1,2'b11,1,0,2'b10);
    vecs[nv++] = mk(1,0,1, 1, 1,2'b01,0,0,2'b01);
    vecs[nv++] = mk(1,0,1, 1, 1,2'b11,0,0,2'b00);
    vecs[nv++] = mk(1,0,1, 1, 1,2'b00,0,0,2'b00);
    vecs[nv++] = mk(1,0,1, 1, 1,2'b00,0,0,2'b00);
    vecs[nv++] = mk(1,0,1, 1, 1,2'b00,0,0,2'b00);
    vecs[nv++] = mk(0,0,1, 0, 1,2'b00,0,0,2'b00);
    vecs[nv++] = mk(0,0,1, 0, 1,2'b00,0,1,2'b00);
    // Frame of all ones (rows 8-15), then idle (row 16)
    vecs[nv++] = mk(1,1,1, 1, 1,2'b11,1,0,2'b10);
    vecs[nv++] = mk(1,1,1, 1, 1,2'b10,0,0,2'b11);
    for (int j = 0; j < 4; j++) vecs[nv++] = mk(1,1,1, 1, 1,2'b01,0,0,2'b11);
    vecs[nv++] = mk(0,0,1, 0, 1,2'b10,0,0,2'b01);
    vecs[nv++] = mk(0,0,1, 0, 1,2'b11,0,1,2'b00);
    vecs[nv++] = mk(0,0,1, 1, 0,2'b00,0,0,2'b00);
    // Mid-frame stall of 5 cycles (rows 17-29)
    vecs[nv++] = mk(1,1,1, 1, 1,2'b11,1,0,2'b10);
    for (int j = 0; j < 5; j++) vecs[nv++] = mk(1,0,0, 0, 1,2'b11,1,0,2'b10);
    vecs[nv++] = mk(1,0,1, 1, 1,2'b01,0,0,2'b01);
    vecs[nv++] = mk(1,0,1, 1, 1,2'b11,0,0,2'b00);
    for (int j = 0; j < 3; j++) vecs[nv++] = mk(1,0,1, 1, 1,2'b00,0,0,2'b00);
    vecs[nv++] = mk(0,0,1, 0, 1,2'b00,0,0,2'b00);
    vecs[nv++] = mk(0,0,1, 0, 1,2'b00,0,1,2'b00);
    // All-ones frame with back-pressure across the tail (rows 30-41)
    vecs[nv++] = mk(1,1,1, 1, 1,2'b11,1,0,2'b10);
    vecs[nv++] = mk(1,1,1, 1, 1,2'b10,0,0,2'b11);
    for (int j = 0; j < 4; j++) vecs[nv++] = mk(1,1,1, 1, 1,2'b01,0,0,2'b11);
    vecs[nv++] = mk(0,0,0, 0, 1,2'b01,0,0,2'b11);
    vecs[nv++] = mk(0,0,1, 0, 1,2'b10,0,0,2'b01);
    vecs[nv++] = mk(0,0,0, 0, 1,2'b10,0,0,2'b01);
    vecs[nv++] = mk(0,0,0, 0, 1,2'b10,0,0,2'b01);
    vecs[nv++] = mk(0,0,1, 0, 1,2'b11,0,1,2'b00);
    vecs[nv++] = mk(0,0,1, 1, 0,2'b00,0,0,2'b00);

    // ---------------- reset ----------------
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    enc_ready = 1'b1;
    #1;
    check("reset_outputs", {10'b0, enc_valid, enc_out, frame_start, frame_end, enc_state}, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_din_ready", {15'b0, din_ready}, 16'h1);
    $display("reset released: v=%b out=%b st=%b dr=%b", enc_valid, enc_out, enc_state, din_ready);

    // ---------------- directed tables ----------------
    run_rows(0, 7, "t1_impulse");
    run_rows(8, 16, "t2_ones");
    run_rows(17, 29, "t3_stall");
    run_rows(30, 41, "t4_tail_bp");

    // ---------------- reset mid-frame ----------------
    run_rows(0, 2, "t5_pre");
    @(negedge clk);
    din_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("t5_async_clear", {10'b0, enc_valid, enc_out, frame_start, frame_end, enc_state}, 16'h0);
    $display("t5 reset asserted: v=%b out=%b st=%b", enc_valid, enc_out, enc_state);
    @(negedge clk);
    rst = 1'b1;
    run_rows(0, 7, "t5_post");
    run_rows(16, 16, "t5_drain");

    // ---------------- random frames ----------------
    for (int i = 0; i < NB; i++) rbits[i] = 1'($urandom_range(0, 1));
    for (int f = 0; f < NF; f++)
      for (int n = 0; n < 8; n++)
        esym[f * 8 + n] = {ub(f, n) ^ ub(f, n - 2), ub(f, n) ^ ub(f, n - 1) ^ ub(f, n - 2)};

    begin
      int bi = 0;
      int si = 0;
      int cyc = 0;
      logic [15:0] word = 16'h0;
      logic [15:0] eword;
      while (si < NS && cyc < 80000) begin
        @(negedge clk);
        din_valid = (bi < NB) && ($urandom_range(0, 3) != 0);
        din       = (bi < NB) ? rbits[bi] : 1'b0;
        enc_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (enc_valid && enc_ready) begin
          check($sformatf("rnd_sym%0d", si), {12'b0, enc_out, frame_start, frame_end},
                {12'b0, esym[si], 1'(si % 8 == 0), 1'(si % 8 == 7)});
          word = {word[13:0], enc_out};
          if (si % 8 == 7) begin
            eword = 16'h0;
            for (int j = 0; j < 8; j++) eword = {eword[13:0], esym[si - 7 + j]};
            check($sformatf("rnd_word%0d", si / 8), word, eword);
            $display("frame %0d: word=%h expected=%h", si / 8, word, eword);
          end
          si++;
        end
        if (din_valid && din_ready) bi++;
        cyc++;
      end
      check("rnd_all_symbols_seen", 16'(si), 16'(NS));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
